// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  // Access sequencing: one grant cycle, one memory cycle, one ready cycle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Port identity; bit position matches the request/grant vector index.
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory bus and status of the arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int addr_width = ADDR_W_DEF,
  parameter int data_width = DATA_W_DEF
);

  // Fetch port (read only)
  logic                  if_req;
  logic [addr_width-1:0] if_addr;
  logic                  if_ready;
  logic [data_width-1:0] if_rdata;

  // Data port (read/write)
  logic                  dm_req;
  logic                  dm_wr;
  logic [addr_width-1:0] dm_addr;
  logic [data_width-1:0] dm_wdata;
  logic                  dm_ready;
  logic [data_width-1:0] dm_rdata;

  // Main memory bus; read data is combinational from mem_addr
  logic [addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_wdata;
  logic                  mem_wr;
  logic [data_width-1:0] mem_rdata;

  logic                  busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
    output if_ready, if_rdata, dm_ready, dm_rdata, mem_addr, mem_wdata, mem_wr, busy
  );

  // Requesters and memory side
  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata,
    input  if_ready, if_rdata, dm_ready, dm_rdata, mem_addr, mem_wdata, mem_wr, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, the port not granted last wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  output logic [1:0] grant
);

  // One-hot grant; a lone requester always wins
  always_comb begin
    grant = 2'b00;
    if (req[OWN_FETCH] && (!req[OWN_DATA] || last == OWN_DATA)) begin
      grant[OWN_FETCH] = 1'b1;
    end else if (req[OWN_DATA]) begin
      grant[OWN_DATA] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-cycle memory.
// Each access runs IDLE -> ACCESS -> DONE; ready pulses in DONE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int addr_width = ADDR_W_DEF,
  parameter int data_width = DATA_W_DEF
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  state_e                r_state;
  state_e                w_state_next;
  owner_e                r_owner;
  owner_e                r_last;
  logic [addr_width-1:0] r_mem_addr;
  logic [data_width-1:0] r_mem_wdata;
  logic                  r_mem_wr;
  logic [data_width-1:0] r_if_rdata;
  logic [data_width-1:0] r_dm_rdata;
  logic [1:0]            w_grant;
  logic                  w_take;
  logic                  w_if_ready;
  logic                  w_dm_ready;

  rr_pick2 u_pick (
    .req   ({bus.dm_req, bus.if_req}),
    .last  (r_last),
    .grant (w_grant)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, grant strobe and ready pulses
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_if_ready   = 1'b0;
    w_dm_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_state_next = ST_ACCESS;
          w_take       = 1'b1;
        end
      end
      ST_ACCESS: w_state_next = ST_DONE;
      ST_DONE: begin
        w_state_next = ST_IDLE;
        w_if_ready   = (r_owner == OWN_FETCH);
        w_dm_ready   = (r_owner == OWN_DATA);
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request capture on grant, read data capture at the end of ACCESS.
  // r_mem_wr is high only through ACCESS, so it also marks a data write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_FETCH;
      r_last      <= OWN_FETCH;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wr    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      if (w_take) begin
        if (w_grant[OWN_DATA]) begin
          r_owner     <= OWN_DATA;
          r_last      <= OWN_DATA;
          r_mem_addr  <= bus.dm_addr;
          r_mem_wdata <= bus.dm_wdata;
          r_mem_wr    <= bus.dm_wr;
        end else begin
          r_owner     <= OWN_FETCH;
          r_last      <= OWN_FETCH;
          r_mem_addr  <= bus.if_addr;
          r_mem_wr    <= 1'b0;
        end
      end
      if (r_state == ST_ACCESS) begin
        r_mem_wr <= 1'b0;
        if (r_owner == OWN_FETCH) begin
          r_if_rdata <= bus.mem_rdata;
        end else if (!r_mem_wr) begin
          r_dm_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.if_ready  = w_if_ready;
  assign bus.dm_ready  = w_dm_ready;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule
